// File: rtl/toy_mem_pkg.sv
// toy_mem_pkg: shared types and constants for the toy memory responder
package toy_mem_pkg;
  localparam int AW_DEFAULT = 10;
  localparam logic DRW_READ = 1'b0;
  localparam logic DRW_WRITE = 1'b1;
  typedef enum logic {CLEAR, SERVE} state_t;
endpackage

// File: rtl/toy_mem_array.sv
// toy_mem_array: word storage with one write port and two registered read ports, write-first
module toy_mem_array
  import toy_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re_a,
  input  logic          ok_a,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic          re_b,
  input  logic          ok_b,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);
  logic [31:0] mem [2**AW];
  logic [31:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  // storage itself is never reset; the clear sweep rewrites it
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // read outputs hold without a request, load zero when out of range, bypass a same-edge write
  always_comb begin
    rdata_a_d = !re_a ? rdata_a_q : !ok_a ? '0 : (we && waddr == raddr_a) ? wdata : mem[raddr_a];
    rdata_b_d = !re_b ? rdata_b_q : !ok_b ? '0 : (we && waddr == raddr_b) ? wdata : mem[raddr_b];
  end
  // read output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
endmodule

// File: rtl/toy_mem_responder.sv
// toy_mem_responder: instruction/data memory responder with post-reset clear sweep and sticky range error
module toy_mem_responder
  import toy_mem_pkg::*;
#(
  parameter int          AW       = AW_DEFAULT,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IREQ,
  input  logic [29:0] IADDR,
  output logic [31:0] INSTR,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        INIT_DONE,
  output logic        ERR
);
  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          serve, i_ok, d_ok, we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  // sweep vs. serve: write-port mux, range checks, next state and error
  always_comb begin
    serve = state_q == SERVE;
    i_ok = (IADDR >> AW) == '0;
    d_ok = (DADDR >> AW) == '0;
    we = serve ? DREQ && DRW == DRW_WRITE && d_ok : 1'b1;
    waddr = serve ? DADDR[AW-1:0] : cnt_q[AW-1:0];
    wdata = serve ? DWDATA : INIT_VAL;
    cnt_d = serve ? cnt_q : cnt_q + (AW+1)'(1);
    state_d = (!serve && cnt_q == {1'b0, {AW{1'b1}}}) ? SERVE : state_q;
    err_d = err_q | (serve & ((IREQ & !i_ok) | (DREQ & !d_ok)));
  end
  // state, sweep counter and sticky error registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign INIT_DONE = serve;
  assign ERR = err_q;
  toy_mem_array #(.AW(AW)) u_array (
    .clk    (CLK),
    .rst    (RST),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re_a   (serve && IREQ),
    .ok_a   (i_ok),
    .raddr_a(IADDR[AW-1:0]),
    .rdata_a(INSTR),
    .re_b   (serve && DREQ && DRW == DRW_READ),
    .ok_b   (d_ok),
    .raddr_b(DADDR[AW-1:0]),
    .rdata_b(DRDATA)
  );
endmodule

// File: tb/tb_toy_mem_responder.sv
// tb_toy_mem_responder: directed and random checks against a word-array reference model
module tb_toy_mem_responder;
  localparam int AW = 10;
  localparam int N = 1 << AW;
  logic        CLK = 1'b0;
  logic        RST;
  logic        IREQ, DREQ, DRW, INIT_DONE, ERR;
  logic [29:0] IADDR, DADDR;
  logic [31:0] DWDATA, INSTR, DRDATA;
  int          total = 0;
  int          fails = 0;
  logic [31:0] mem [N];
  logic [31:0] e_instr, e_drd;
  logic        e_err;
  int          n;

  toy_mem_responder #(.AW(AW), .INIT_VAL(32'h0)) dut (
    .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
    .INIT_DONE(INIT_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IREQ = 0; DREQ = 0; DRW = 0; IADDR = 0; DADDR = 0; DWDATA = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_instr"}, INSTR, e_instr);
    chk({tag, "_drdata"}, DRDATA, e_drd);
    chk({tag, "_err"}, {31'b0, ERR}, {31'b0, e_err});
    chk({tag, "_init_done"}, {31'b0, INIT_DONE}, 32'd1);
  endtask

  // one serving cycle: apply the request, predict from the word array, check after the edge
  task automatic cyc(input string tag, input logic ireq, input logic [29:0] ia,
                     input logic dreq, input logic drw, input logic [29:0] da, input logic [31:0] wd);
    bit i_in, d_in;
    IREQ = ireq; IADDR = ia; DREQ = dreq; DRW = drw; DADDR = da; DWDATA = wd;
    i_in = ia < N;
    d_in = da < N;
    if (dreq && drw && d_in) mem[da[AW-1:0]] = wd;
    if (ireq) e_instr = i_in ? mem[ia[AW-1:0]] : 32'h0;
    if (dreq && !drw) e_drd = d_in ? mem[da[AW-1:0]] : 32'h0;
    if ((ireq && !i_in) || (dreq && !d_in)) e_err = 1'b1;
    tick();
    chk_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    RST = 1;
    e_instr = 0; e_drd = 0; e_err = 0;
    foreach (mem[i]) mem[i] = 32'h0;
    repeat (3) tick();
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_drdata", DRDATA, 32'h0);
    chk("rst_err", {31'b0, ERR}, 32'h0);
    chk("rst_init_done", {31'b0, INIT_DONE}, 32'h0);
    RST = 0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 100) begin
        IREQ = 1; IADDR = 30'h400; DREQ = 1; DRW = 1; DADDR = 30'h400; DWDATA = 32'h55;
      end else idle();
      tick();
    end
    idle();
    chk("sweep1_err", {31'b0, ERR}, 32'h0);
    chk("sweep1_init_done", {31'b0, INIT_DONE}, 32'h0);
    chk("sweep1_instr", INSTR, 32'h0);
    RST = 1;
    tick();
    chk("midrst_init_done", {31'b0, INIT_DONE}, 32'h0);
    chk("midrst_err", {31'b0, ERR}, 32'h0);
    RST = 0;
    n = 0;
    while (!INIT_DONE && n < 2000) begin
      if (n == 100) begin
        IREQ = 0; DREQ = 1; DRW = 1; DADDR = 30'd3; DWDATA = 32'h1234;
      end else if (n == 101) begin
        IREQ = 1; IADDR = 30'h7FF; DREQ = 1; DRW = 0; DADDR = 30'h400;
      end else idle();
      tick();
      n++;
    end
    idle();
    chk("sweep2_len", n, N);
    chk("sweep2_err", {31'b0, ERR}, 32'h0);
    chk("sweep2_instr", INSTR, 32'h0);
    chk("sweep2_drdata", DRDATA, 32'h0);
    cyc("rd0_511", 1, 30'd0, 1, 0, 30'd511, 0);
    cyc("rd1023_3", 1, 30'd1023, 1, 0, 30'd3, 0);
    chk("word3_cleared", DRDATA, 32'h0);
    cyc("hold", 0, 30'd0, 0, 0, 30'd0, 0);
    cyc("wr5_bypass", 1, 30'd5, 1, 1, 30'd5, 32'hDEADBEEF);
    chk("wr5_instr", INSTR, 32'hDEADBEEF);
    cyc("rd5", 0, 30'd0, 1, 0, 30'd5, 0);
    chk("rd5_drdata", DRDATA, 32'hDEADBEEF);
    cyc("oor_ifetch", 1, 30'h400, 0, 0, 30'd0, 0);
    chk("oor_instr", INSTR, 32'h0);
    chk("oor_err", {31'b0, ERR}, 32'h1);
    cyc("oor_write", 0, 30'd0, 1, 1, 30'h400, 32'hCAFEF00D);
    cyc("rd_word0", 1, 30'd0, 1, 0, 30'd0, 0);
    chk("word0_instr", INSTR, 32'h0);
    chk("word0_drdata", DRDATA, 32'h0);
    chk("err_sticky", {31'b0, ERR}, 32'h1);
    for (int k = 0; k < 200; k++) begin
      logic        ir, dr, rw;
      logic [29:0] ia, da;
      ir = ($urandom % 4) != 0;
      dr = ($urandom % 4) != 0;
      rw = $urandom % 2;
      ia = ($urandom % 16 == 0) ? 30'($urandom) | 30'h400 : 30'($urandom % 16);
      da = ($urandom % 16 == 0) ? 30'($urandom) | 30'h400 : 30'($urandom % 16);
      cyc("rand", ir, ia, dr, rw, da, $urandom);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/toy_mem_responder.md
# toy_mem_responder

Memory-side responder for the RISC_TOY core's instruction and data request interfaces. Serves instruction fetches (IREQ/IADDR/INSTR) and data reads/writes (DREQ/DRW/DADDR/DWDATA/DRDATA) from one shared word array with fixed one-cycle read latency. After reset it runs a sequential clear sweep before accepting requests, and it flags out-of-range accesses with a sticky error bit. It is instantiated beside the core in the top-level and in the core testbench.

## Interface
- AW, default 10: word-address bits implemented; array holds 2^AW 32-bit words.
- INIT_VAL, default 32'h0000_0000: value written to every word during the clear sweep.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- IREQ  input  1  instruction fetch request.
- IADDR  input  30  instruction word address.
- INSTR  output  32  fetched word; registered.
- DREQ  input  1  data request.
- DRW  input  1  1 = write, 0 = read.
- DADDR  input  30  data word address.
- DWDATA  input  32  write data.
- DRDATA  output  32  read data; registered.
- INIT_DONE  output  1  high once the clear sweep completes.
- ERR  output  1  sticky out-of-range access flag.

## Operation
- FSM states: CLEAR, SERVE.
- Reset (RST high, any cycle, including mid-sweep): state = CLEAR, sweep counter = 0, INSTR = 0, DRDATA = 0, INIT_DONE = 0, ERR = 0. Array contents are not reset directly; the sweep rewrites them.
- CLEAR: each cycle writes INIT_VAL to word[counter]. Counter is AW+1 bits wide. When counter reaches 2^AW-1, the FSM enters SERVE on the next edge and INIT_DONE goes high. All requests in CLEAR are ignored: no writes, INSTR/DRDATA stay 0, ERR unchanged.
- SERVE, in range: an address is in range when bits [29:AW] are all zero; only bits [AW-1:0] index the array.
- Instruction read: IREQ and IADDR in range -> INSTR <= word[IADDR] at the next edge.
- Data read: DREQ, DRW=0, in range -> DRDATA <= word[DADDR] at the next edge.
- Data write: DREQ, DRW=1, in range -> word[DADDR] <= DWDATA at the edge. DRDATA holds its previous value.
- No request on a port: that port's output holds its last value.
- Out of range, either port: reads load 0 into the output, writes are dropped, ERR <= 1. ERR clears only on reset.
- Simultaneous data write and instruction read to the same in-range address: write-first; INSTR returns the new DWDATA.
- Data read of the address written in the previous cycle returns the written value, with no extra hazard.

## Timing
- Read latency: exactly 1 cycle, for both ports. A request sampled at edge N produces output valid after edge N, held until the next request on that port.
- Write takes effect at the sampling edge and is visible to any read sampled at the next edge. Same-edge instruction reads see it through the bypass.
- Clear sweep: 2^AW cycles after reset deasserts. INIT_DONE rises at edge 2^AW (1024 for default AW).
- Both ports are serviced every cycle. No back-pressure and no ready signal; the core must not issue requests before INIT_DONE.

## Structure
- Shared package `toy_mem_pkg`:
  - state enum {CLEAR, SERVE}
  - DRW encoding constants: DRW_READ = 0, DRW_WRITE = 1
  - default AW
- Sub-module `toy_mem_array`: 2^AW x 32 storage with 1 write port and 2 synchronous read ports. Write-first bypass lives inside it.
- `toy_mem_responder` holds:
  - the FSM and sweep counter
  - range check and ERR logic
  - the write-port mux (sweep vs. DADDR/DWDATA)

## Test plan
- Reset then idle: INSTR = DRDATA = 0, ERR = 0. INIT_DONE rises exactly 1024 cycles after RST falls. Reads of words 0, 511, 1023 all return 0.
- Write 0xDEADBEEF to DADDR 5, then read DADDR 5 on the next cycle -> DRDATA = 0xDEADBEEF one cycle after the read request. Same-cycle IREQ to IADDR 5 during the write -> INSTR = 0xDEADBEEF.
- IREQ to IADDR 0x400 (bit 10 set) -> INSTR = 0, ERR = 1 and stays 1. A following write to DADDR 0x400 does not alter word 0.
- RST pulse at cycle 300 of the sweep -> INIT_DONE stays 0 and the sweep restarts. INIT_DONE rises 1024 cycles after the second RST falls.
- Requests during CLEAR (write 0x1234 to DADDR 3) -> ignored. After INIT_DONE, word 3 reads 0 and ERR = 0.
- Back-to-back mixed traffic for 200 random cycles, checked against a scoreboard model: every read returns the last written value with 1-cycle latency, and outputs hold when there is no request.
